// File: rtl/loac_pkg.sv
// -----------------------------------------------------------------------------
// loac_pkg
// Shared constants and types for the switch debouncer.
//   NBITS_TOP           : default number of switch channels
//   DEBOUNCE_CYCLES_DEF : default number of consecutive stable cycles required
//   CNT_W_DEF           : per-bit counter width for the default threshold
//   cnt_width()         : counter width for any threshold (never below 1 bit)
//   cnt_action_e        : what a per-bit counter does on the next edge
// -----------------------------------------------------------------------------
package loac_pkg;

    localparam int unsigned NBITS_TOP           = 32'd8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd4;

    // ceil(log2(cycles)), with a floor of one bit so a counter always exists.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

    typedef enum logic [1:0] {
        ACT_CLEAR  = 2'd0,  // input agrees with the accepted level
        ACT_COUNT  = 2'd1,  // input disagrees, threshold not yet reached
        ACT_ACCEPT = 2'd2   // input disagreed long enough: take the new level
    } cnt_action_e;

endpackage

// File: rtl/swi_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One debounced switch channel: two-flop synchronizer, stability counter,
// accepted-level flop and one-cycle rise/fall pulses.
// Ports:
//   clk_2  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   swi    : raw, asynchronous switch level
//   stable : accepted (debounced) level
//   rise   : one-cycle pulse on an accepted 0->1 change
//   fall   : one-cycle pulse on an accepted 1->0 change
// -----------------------------------------------------------------------------
module debounce_bit
    import loac_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic swi,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync_meta_r;
    logic             sync_q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;
    logic             rise_r;
    logic             fall_r;

    cnt_action_e      action_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             stable_next_s;
    logic             rise_next_s;
    logic             fall_next_s;

    // Two-flop synchronizer; reset to the accepted reset level so that a
    // switch already at that level produces no spurious count after release.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= RESET_BIT;
            sync_q_r    <= RESET_BIT;
        end else begin
            sync_meta_r <= swi;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Decide what the counter does this cycle. The >= compare makes the
    // counter saturate at the threshold rather than ever wrapping.
    always_comb begin
        action_s = ACT_CLEAR;
        if (sync_q_r == stable_r) begin
            action_s = ACT_CLEAR;
        end else if (cnt_r >= CNT_LAST) begin
            action_s = ACT_ACCEPT;
        end else begin
            action_s = ACT_COUNT;
        end
    end

    // Next-state values for counter, accepted level and edge pulses.
    always_comb begin
        cnt_next_s    = CNT_ZERO;
        stable_next_s = stable_r;
        rise_next_s   = 1'b0;
        fall_next_s   = 1'b0;
        case (action_s)
            ACT_CLEAR: begin
                cnt_next_s = CNT_ZERO;
            end
            ACT_COUNT: begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
            ACT_ACCEPT: begin
                cnt_next_s    = CNT_ZERO;
                stable_next_s = sync_q_r;
                rise_next_s   = sync_q_r;
                fall_next_s   = ~sync_q_r;
            end
            default: begin
                cnt_next_s    = CNT_ZERO;
                stable_next_s = stable_r;
            end
        endcase
    end

    // Counter, accepted level and pulse registers.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= RESET_BIT;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            stable_r <= stable_next_s;
            rise_r   <= rise_next_s;
            fall_r   <= fall_next_s;
        end
    end

    assign stable = stable_r;
    assign rise   = rise_r;
    assign fall   = fall_r;

endmodule

// File: rtl/swi_debounce.sv
// -----------------------------------------------------------------------------
// swi_debounce
// NBITS independent switch debouncers plus a registered "any change" flag.
// Ports:
//   clk_2      : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   SWI        : raw bouncing switch levels (NBITS)
//   sw_stable  : debounced levels (NBITS)
//   sw_rise    : one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall    : one-cycle pulse per bit on an accepted 1->0 change
//   sw_changed : high the cycle after any rise/fall pulse
// -----------------------------------------------------------------------------
module swi_debounce
    import loac_pkg::*;
#(
    parameter int unsigned      NBITS           = NBITS_TOP,
    parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [NBITS-1:0] RESET_VAL       = {NBITS{1'b0}}
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [NBITS-1:0] SWI,
    output logic [NBITS-1:0] sw_stable,
    output logic [NBITS-1:0] sw_rise,
    output logic [NBITS-1:0] sw_fall,
    output logic             sw_changed
);

    logic pulse_any_s;
    logic sw_changed_r;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_bit (
            .clk_2  (clk_2),
            .rst_n  (rst_n),
            .swi    (SWI[i]),
            .stable (sw_stable[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    assign pulse_any_s = |(sw_rise | sw_fall);

    // Registered OR of every pulse: trails the pulses by exactly one cycle.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sw_changed_r <= 1'b0;
        end else begin
            sw_changed_r <= pulse_any_s;
        end
    end

    assign sw_changed = sw_changed_r;

endmodule

// File: tb/tb_swi_debounce.sv
// -----------------------------------------------------------------------------
// tb_swi_debounce
// Scoreboarded bench: a behavioural model (input delay line + per-bit run
// lengths) pushes the expected outputs every edge, a monitor pops and compares
// on the falling edge. Directed scenarios add fixed-value checks; a second
// instance with a threshold of 2 covers the short-latency build.
// -----------------------------------------------------------------------------
module tb_swi_debounce;

    localparam int         DC = 4;
    localparam logic [7:0] RV = 8'h00;

    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] swi   = 8'hFF;
    logic [7:0] sw_stable, sw_rise, sw_fall;
    logic       sw_changed;
    logic [7:0] swi2  = 8'h00;
    logic [7:0] stable2, rise2, fall2;
    logic       changed2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sb     = 0;

    logic [24:0] exp_q[$];

    always #5 clk_2 = ~clk_2;

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(4), .RESET_VAL(8'h00)) dut (
        .clk_2(clk_2), .rst_n(rst_n), .SWI(swi),
        .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .sw_changed(sw_changed)
    );

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(2), .RESET_VAL(8'h00)) dut2 (
        .clk_2(clk_2), .rst_n(rst_n), .SWI(swi2),
        .sw_stable(stable2), .sw_rise(rise2), .sw_fall(fall2),
        .sw_changed(changed2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_stable, m_rise, m_fall;
    logic       m_changed;
    logic [7:0] m_samp[$];
    int         m_run[8];

    task automatic model_reset();
        m_stable  = RV;
        m_rise    = 8'h00;
        m_fall    = 8'h00;
        m_changed = 1'b0;
        m_samp    = {RV, RV};
        foreach (m_run[i]) m_run[i] = 0;
        exp_q.delete();
    endtask

    // The switch level seen by the acceptance rule is the one sampled two
    // edges earlier; a bit is accepted once it has disagreed for DC edges.
    task automatic model_edge();
        logic [7:0] delayed, nr, nf;
        delayed = m_samp.pop_front();
        m_samp.push_back(swi);
        m_changed = |(m_rise | m_fall);
        nr = 8'h00;
        nf = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (delayed[i] != m_stable[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DC) begin
                    m_stable[i] = delayed[i];
                    nr[i]       = delayed[i];
                    nf[i]       = ~delayed[i];
                    m_run[i]    = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_rise = nr;
        m_fall = nf;
        exp_q.push_back({m_stable, m_rise, m_fall, m_changed});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_2 or negedge rst_n);
            if (!rst_n) model_reset();
            else model_edge();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk_2);
            if (rst_n && exp_q.size() > 0) begin
                logic [24:0] e;
                e = exp_q.pop_front();
                n_sb++;
                check("scoreboard", {7'd0, sw_stable, sw_rise, sw_fall, sw_changed}, {7'd0, e});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk_2);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset values while held in reset
        #3;
        check("rst_stable", sw_stable, 8'h00);
        check("rst_rise", sw_rise, 8'h00);
        check("rst_fall", sw_fall, 8'h00);
        check("rst_changed", sw_changed, 1'b0);
        #20;
        rst_n = 1'b1;

        // release with all switches high: accepted on the 6th edge
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_2); #1;
            check("rel_stable", sw_stable, (k < 6) ? 8'h00 : 8'hFF);
            check("rel_rise", sw_rise, (k == 6) ? 8'hFF : 8'h00);
            if (k == 7) check("rel_changed", sw_changed, 1'b1);
        end

        // glitch on bit 0 lasting 3 cycles is rejected
        swi = 8'h00;
        edges(12);
        swi = 8'h01;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk_2); #1;
            check("glitch_stable", sw_stable, 8'h00);
            check("glitch_pulses", {sw_rise, sw_fall}, 16'h0000);
            if (k == 3) swi = 8'h00;
        end

        // bit 7 bounces every 2 cycles, then holds high
        for (int c = 0; c < 20; c++) begin
            swi = {(c % 4) < 2, 7'b0};
            @(posedge clk_2); #2;
            check("bounce_rise", sw_rise, 8'h00);
        end
        swi = 8'h80;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_2); #1;
            check("hold_rise7", sw_rise[7], (k == 6) ? 1'b1 : 1'b0);
            check("hold_stable7", sw_stable[7], (k >= 6) ? 1'b1 : 1'b0);
        end

        // simultaneous rise and fall on different bits
        swi = 8'h0F;
        edges(10);
        check("pre_swap_stable", sw_stable, 8'h0F);
        swi = 8'hF0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_2); #1;
            check("swap_rise", sw_rise, (k == 6) ? 8'hF0 : 8'h00);
            check("swap_fall", sw_fall, (k == 6) ? 8'h0F : 8'h00);
            check("swap_changed", sw_changed, (k == 7) ? 1'b1 : 1'b0);
        end

        // reset two counts into bit 3's change aborts it
        swi = 8'hF8;
        repeat (4) @(posedge clk_2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_stable", sw_stable, 8'h00);
        check("abort_pulses", {sw_rise, sw_fall}, 16'h0000);
        check("abort_changed", sw_changed, 1'b0);
        edges(3);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_2); #1;
            check("reacc_rise", sw_rise, (k == 6) ? 8'hF8 : 8'h00);
            check("reacc_stable", sw_stable, (k < 6) ? 8'h00 : 8'hF8);
        end

        // threshold-2 build: bit 1 accepted on the 4th edge
        swi2 = 8'h02;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_2); #1;
            check("dc2_stable1", stable2[1], (k >= 4) ? 1'b1 : 1'b0);
            check("dc2_rise", rise2, (k == 4) ? 8'h02 : 8'h00);
            check("dc2_fall", fall2, 8'h00);
            check("dc2_changed", changed2, (k == 5) ? 1'b1 : 1'b0);
        end

        // randomized bouncing, checked by the scoreboard
        edges(1);
        for (int c = 0; c < 2500; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: swi = swi ^ (8'h01 << $urandom_range(0, 7));
                3:       swi = 8'($urandom());
                default: swi = swi;
            endcase
            if (c == 1200) rst_n = 1'b0;
            if (c == 1204) rst_n = 1'b1;
            edges(1);
        end
        edges(10);
        check("scoreboard_activity", (n_sb > 2000) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/swi_debounce.md
SWI_DEBOUNCE -- requirements
Module: swi_debounce

Interface
REQ-001 Parameter NBITS, default 8, is the number of switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, is the consecutive stable cycles required to accept a change; legal range 2..255.
REQ-003 Parameter RESET_VAL, default 8'h00, is the reset value of sw_stable.
REQ-004 clk_2  input  1  the single clock; every flop is clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 SWI  input  NBITS  raw, asynchronous, bouncing switch levels.
REQ-007 sw_stable  output  NBITS  debounced switch levels; this output feeds the SWI input of top.
REQ-008 sw_rise  output  NBITS  one-cycle pulse per bit on an accepted 0->1 change.
REQ-009 sw_fall  output  NBITS  one-cycle pulse per bit on an accepted 1->0 change.
REQ-010 sw_changed  output  1  registered OR of all sw_rise and sw_fall bits.

Function
REQ-011 Each SWI bit SHALL pass through a two-flop synchronizer; sync_q is the second flop.
REQ-012 Each bit SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-013 Per bit, when sync_q equals sw_stable, the counter SHALL be cleared to 0 on the next edge.
REQ-014 Per bit, when sync_q differs from sw_stable and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 Per bit, when sync_q differs from sw_stable and the counter equals DEBOUNCE_CYCLES-1, that edge SHALL load sw_stable from sync_q, clear the counter, and assert sw_rise or sw_fall according to the new value.
REQ-016 Latency: a SWI change held constant SHALL appear on sw_stable at the (DEBOUNCE_CYCLES+2)th rising edge after the change (6 edges at the default).
REQ-017 sw_rise and sw_fall SHALL be high for exactly one cycle, coincident with the sw_stable update, and SHALL be low otherwise.
REQ-018 Glitch rule: if sync_q returns to sw_stable before the threshold, the counter SHALL clear and no output SHALL change.
REQ-019 A bit that bounces again after an accepted change SHALL restart its count from 0.
REQ-020 Bits SHALL be fully independent; simultaneous changes on several bits SHALL produce simultaneous pulses.
REQ-021 sw_changed SHALL go high one cycle after any rise or fall pulse and SHALL stay high for one cycle per pulse cycle.
REQ-022 Counters SHALL saturate and never wrap, because REQ-015 clears them at the threshold.

Reset
REQ-023 While rst_n is low, all flops SHALL be forced asynchronously: synchronizers to RESET_VAL, counters to 0, sw_stable to RESET_VAL, sw_rise, sw_fall and sw_changed to 0.
REQ-024 Assertion of rst_n during a count SHALL abort the count; no pulse SHALL be emitted for the aborted change.
REQ-025 Deassertion of rst_n SHALL be followed by normal operation from the first rising edge; a SWI value different from RESET_VAL at release SHALL be accepted after the REQ-016 latency, with a pulse.

Structure
REQ-026 NBITS_TOP-derived width, the DEBOUNCE_CYCLES default and the counter-width constant SHALL live in the shared package loac_pkg.
REQ-027 Per-bit logic SHALL be the sub-module debounce_bit (synchronizer, counter, stable flop, rise/fall), instantiated NBITS times by a generate loop.
REQ-028 The top level SHALL hold only the generate loop and the sw_changed register.

Verification
REQ-029 Reset with SWI=8'hFF, release, hold -> sw_stable=8'h00 for 5 edges, 8'hFF at the 6th edge, sw_rise=8'hFF for one cycle.
REQ-030 Bit 0 high for 3 cycles then low (glitch) -> sw_stable, sw_rise and sw_fall stay 0 throughout.
REQ-031 Bit 7 toggled every 2 cycles for 20 cycles, then held 1 -> a single sw_rise[7] pulse 6 edges after the final hold begins.
REQ-032 Stable 8'h0F, SWI changed to 8'hF0 -> sw_rise=8'hF0 and sw_fall=8'h0F in the same cycle, sw_changed high on the next cycle.
REQ-033 rst_n asserted 2 cycles into the count of bit 3 -> outputs go to reset values immediately; no sw_rise[3] pulse before the REQ-025 re-acceptance.
REQ-034 DEBOUNCE_CYCLES=2 build, bit 1 change -> sw_stable[1] updates at the 4th edge.
